// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller: access size
// encoding, controller state encoding and the default memory base address.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } dmem_state_e;

  function automatic logic [2:0] size_bytes(input dmem_size_e s);
    case (s)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM with per-byte write enables; registered read data.
// Contents have no reset and survive controller resets.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller in front of dmem_array: one request at a time, response
// WAIT_STATES+3 cycles after the handshake cycle. DMEM_MISALIGN_FAULT_EN makes misaligned accesses fault.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [33:0] SPAN_BYTES = 34'(DEPTH_WORDS) * 34'd4;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q, fault_q;
  dmem_size_e  size_q;
  logic [1:0]  lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;

  dmem_size_e  size_in;
  logic [31:0] addr_aligned;
  logic [32:0] offset;
  logic [33:0] end_off;
  logic        out_of_range, fault_in, accept;

  assign size_in = dmem_size_e'(req_size);
  assign accept  = (state_q == ST_IDLE) && req_valid;

  // Range is judged on the naturally aligned address; offset[32] is the borrow for addresses below BASE.
  always_comb begin
    case (size_in)
      SZ_HALF: addr_aligned = {req_addr[31:1], 1'b0};
      SZ_WORD: addr_aligned = {req_addr[31:2], 2'b00};
      default: addr_aligned = req_addr;
    endcase
    offset       = {1'b0, addr_aligned} - {1'b0, BASE_ADDR};
    end_off      = {1'b0, offset} + 34'(size_bytes(size_in));
    out_of_range = offset[32] | (end_off > SPAN_BYTES);
  end

`ifdef DMEM_MISALIGN_FAULT_EN
  logic misaligned;
  assign misaligned = (size_in == SZ_HALF) ? req_addr[0] :
                      (size_in == SZ_WORD) ? |req_addr[1:0] : 1'b0;
  assign fault_in   = out_of_range | (size_in == SZ_ILL) | misaligned;
`else
  assign fault_in   = out_of_range | (size_in == SZ_ILL);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        fault_q <= fault_in;
        size_q  <= size_in;
        lane_q  <= addr_aligned[1:0];
        idx_q   <= offset[AW+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, ld_shift;

  // A faulted request never touches the RAM, so no lanes can be written.
  assign ram_en = (state_q == ST_ACCESS) && !fault_q;

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << lane_q;
        ram_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = lane_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
    if (!we_q) ram_be = 4'b0000;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk),
    .en_i   (ram_en),
    .be_i   (ram_be),
    .addr_i (idx_q),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign ld_shift = ram_rdata >> {lane_q, 3'b000};

  always_comb begin
    rsp_rdata = '0;
    if (state_q == ST_RESP && !fault_q && !we_q) begin
      case (size_q)
        SZ_BYTE: rsp_rdata = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
        SZ_HALF: rsp_rdata = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
        default: rsp_rdata = ram_rdata;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fault = (state_q == ST_RESP) && fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a byte-addressed reference memory,
// plus directed boundary, misalignment and mid-request reset scenarios.
module tb_data_mem_ctrl;

  localparam longint BASE  = 64'h8000_0000;
  localparam int     DEPTH = 1024;
  localparam int     WS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_mem [longint];

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_fault   (rsp_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level memory model: natural-alignment masking, range and size rules.
  function automatic void model(input bit we, input bit [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output bit flt, output logic [31:0] rd);
    int n;
    longint a;
    logic [31:0] v;
    flt = 1'b0;
    rd  = '0;
    if (size == 2'b11) begin
      flt = 1'b1;
      return;
    end
    n = 1 << size;
    a = longint'(addr) & ~longint'(n - 1);
`ifdef DMEM_MISALIGN_FAULT_EN
    if (longint'(addr) != a) flt = 1'b1;
`endif
    if (a < BASE || a + n - 1 > BASE + 4 * DEPTH - 1) flt = 1'b1;
    if (flt) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem.exists(a + i) ? ref_mem[a + i] : 8'h00;
      if (n < 4 && !uns && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hff;
      end
      rd = v;
    end
  endfunction

  task automatic do_txn(input bit we, input bit [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output bit flt);
    bit          ef;
    logic [31:0] er;
    int          cyc;
    bit          seen;
    rd  = '0;
    flt = 1'b0;
    @(negedge clk);
    check_eq("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble fields after the handshake; the captured request must not change.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    model(we, size, uns, addr, wdata, ef, er);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) check_eq("busy_not_ready", {31'b0, req_ready}, 32'd0);
      if (rsp_valid) seen = 1'b1;
    end
    check_eq("latency", cyc, WS + 3);
    if (seen) begin
      rd  = rsp_rdata;
      flt = rsp_fault;
      check_eq($sformatf("rdata@%h", addr), rsp_rdata, er);
      check_eq($sformatf("fault@%h", addr), {31'b0, rsp_fault}, {31'b0, ef});
      @(negedge clk);
      check_eq("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
      check_eq("ready_after_resp", {31'b0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          flt;
    int          pulses;
    logic [31:0] addr;
    bit [1:0]    size;

    @(negedge clk);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0000 + 32'(4 * i), $urandom, rd, flt);
      do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0FC0 + 32'(4 * i), $urandom, rd, flt);
    end

    do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h11ab_cdef, rd, flt);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, rd, flt);
    check_eq("d_word_load", rd, 32'h11ab_cdef);
    check_eq("d_word_fault", {31'b0, flt}, 32'd0);

    do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h0, rd, flt);
    do_txn(1'b1, 2'b00, 1'b0, 32'h8000_0011, 32'h11, rd, flt);
    do_txn(1'b1, 2'b01, 1'b0, 32'h8000_0012, 32'h2333, rd, flt);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, rd, flt);
    check_eq("d_lane_merge", rd, 32'h2333_1100);

    do_txn(1'b0, 2'b00, 1'b0, 32'h8000_0002, 32'h0, rd, flt);
    check_eq("d_byte_signed", rd, 32'hffff_ffab);
    do_txn(1'b0, 2'b00, 1'b1, 32'h8000_0002, 32'h0, rd, flt);
    check_eq("d_byte_unsigned", rd, 32'h0000_00ab);

    do_txn(1'b0, 2'b10, 1'b0, 32'h7fff_fffc, 32'h0, rd, flt);
    check_eq("d_below_fault", {31'b0, flt}, 32'd1);
    check_eq("d_below_rdata", rd, 32'd0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_1000, 32'h0, rd, flt);
    check_eq("d_above_fault", {31'b0, flt}, 32'd1);
    check_eq("d_above_rdata", rd, 32'd0);
    do_txn(1'b1, 2'b10, 1'b0, 32'h8000_1000, 32'h55aa_55aa, rd, flt);
    do_txn(1'b1, 2'b10, 1'b0, 32'h7fff_fffc, 32'h55aa_55aa, rd, flt);
    do_txn(1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h55aa_55aa, rd, flt);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, rd, flt);
    check_eq("d_oob_store_kept", rd, 32'h11ab_cdef);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0ffc, 32'h0, rd, flt);

    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, rd, flt);
`ifdef DMEM_MISALIGN_FAULT_EN
    check_eq("d_misalign_fault", {31'b0, flt}, 32'd1);
    check_eq("d_misalign_rdata", rd, 32'd0);
`else
    check_eq("d_misalign_fault", {31'b0, flt}, 32'd0);
    check_eq("d_misalign_rdata", rd, 32'h11ab_cdef);
`endif

    // Abort a store while it is waiting; the RAM must keep the old word.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8000_0000; req_wdata = 32'hdead_beef;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    pulses = 0;
    @(negedge clk);
    if (rsp_valid) pulses++;
    check_eq("abort_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    if (rsp_valid) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check_eq("abort_no_pulse", pulses, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, rd, flt);
    check_eq("abort_old_data", rd, 32'h11ab_cdef);

    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h7fff_ffc0 + 32'($urandom_range(0, 63));
        1:       addr = 32'h8000_1000 + 32'($urandom_range(0, 63));
        2, 3, 4: addr = 32'h8000_0fc0 + 32'($urandom_range(0, 63));
        default: addr = 32'h8000_0000 + 32'($urandom_range(0, 63));
      endcase
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom), size, 1'($urandom), addr, $urandom, rd, flt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=4).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and access (0..15).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  controller can accept a request.
REQ-008 SHALL have port req_we  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal.
REQ-010 SHALL have port req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
REQ-011 SHALL have port req_addr  in  32  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-015 SHALL have port rsp_fault  out  1  access rejected, valid with rsp_valid.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; WAIT skipped when WAIT_STATES=0.
REQ-017 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready at rising edge.
REQ-018 SHALL register all request fields at handshake; later input changes have no effect.
REQ-019 SHALL count WAIT_STATES cycles in WAIT with a down-counter loaded at handshake.
REQ-020 SHALL perform the RAM read or byte-enabled write on the edge leaving ACCESS.
REQ-021 SHALL assert rsp_valid for exactly one cycle in RESP, WAIT_STATES+3 cycles after the handshake edge.
REQ-022 SHALL write only the addressed lanes: byte lane addr[1:0]; half lanes addr[1]*2 +{0,1}; word all four.
REQ-023 SHALL return loads shifted to bit 0 and extended per req_unsigned to 32 bits; word ignores req_unsigned.
REQ-024 SHALL fault when address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1] or req_size=11, with no RAM write.
REQ-025 SHALL treat an access whose last byte crosses the top boundary as out-of-range.
REQ-026 SHALL accept a new request one cycle after RESP (IDLE); no overlap of requests.

Reset
REQ-027 SHALL, on rst high, immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_fault=0, counter=0.
REQ-028 SHALL preserve RAM contents across reset; reset during WAIT/ACCESS aborts the request with no write unless the ACCESS edge already occurred.

Configuration
REQ-029 SHALL honour macro DMEM_MISALIGN_FAULT_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 faults, no write; undefined -> low address bits are masked to natural alignment and the access proceeds.

Structure
REQ-030 SHALL place size encoding enum, FSM state enum and default BASE_ADDR constant in package dmem_pkg.
REQ-031 SHALL instantiate sub-module dmem_array (DEPTH_WORDS x 32, 4-bit byte enable, synchronous read/write, no reset).

Verification
REQ-032 SHALL check: word store 32'h11abcdef at 0x80000000, word load -> rsp_rdata 32'h11abcdef, fault 0.
REQ-033 SHALL check: byte store 0x11 at 0x80000011, half store 0x2333 at 0x80000012, word load 0x80000010 -> 32'h23331100.
REQ-034 SHALL check: byte load signed at 0x80000002 of 0x11abcdef -> 32'hffffffab; unsigned -> 32'h000000ab.
REQ-035 SHALL check: load at 0x7ffffffc and at BASE+4*DEPTH_WORDS -> fault 1, rdata 0; store there leaves RAM unchanged.
REQ-036 SHALL check: word load at 0x80000002 -> fault 1 with DMEM_MISALIGN_FAULT_EN, else 32'h11abcdef from 0x80000000.
REQ-037 SHALL check: rst pulse during WAIT of store 0xdeadbeef -> old data retained, rsp_valid never pulses, next request completes in WAIT_STATES+3 cycles.
